// File: rtl/cpu_ex_md_pkg.sv
// cpu_ex_md_pkg
//   Shared encodings for the execute stage and its multiply/divide unit:
//   the decoded-controls word layout, ALU operations, PC-select codes,
//   R-type funct codes for the HI/LO instructions, the mul/div operation
//   class and the mul/div FSM states. It also holds two helpers: the
//   mul/div decoder and the ALU.
package cpu_ex_md_pkg;

    // Decoded controls word produced by the ID stage
    localparam int CON_W          = 16;
    localparam int CON_ALU_OP_LSB = 0;   // 4-bit ALU operation
    localparam int CON_ALU_SRC_IMM = 4;  // operand B is the extended immediate
    localparam int CON_SIGN_EXT   = 5;   // immediate is sign- (else zero-) extended
    localparam int CON_REG_WRITE  = 6;
    localparam int CON_REG_DST_RD = 7;   // destination rd (else rt)
    localparam int CON_LINK       = 8;   // write PC+4 to $31
    localparam int CON_BEQ        = 9;
    localparam int CON_BNE        = 10;
    localparam int CON_JUMP       = 11;
    localparam int CON_JR         = 12;
    localparam int CON_MEM_READ   = 13;
    localparam int CON_MEM_WRITE  = 14;
    localparam int CON_SYSCALL    = 15;

    localparam logic [CON_W-1:0] CON_NOP = '0;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] PC_INC_NORMAL       = 2'b00;
    localparam logic [1:0] PC_INC_TAKE         = 2'b01;
    localparam logic [1:0] PC_INC_STOP_OR_MASK = 2'b10;

    localparam logic [5:0] OP_RTYPE      = 6'h00;
    localparam logic [5:0] INS_R_SYSCALL = 6'h0C;
    localparam logic [5:0] INS_R_MFHI    = 6'h10;
    localparam logic [5:0] INS_R_MTHI    = 6'h11;
    localparam logic [5:0] INS_R_MFLO    = 6'h12;
    localparam logic [5:0] INS_R_MTLO    = 6'h13;
    localparam logic [5:0] INS_R_MULT    = 6'h18;
    localparam logic [5:0] INS_R_MULTU   = 6'h19;
    localparam logic [5:0] INS_R_DIV     = 6'h1A;
    localparam logic [5:0] INS_R_DIVU    = 6'h1B;

    typedef enum logic [3:0] {
        MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
        MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE, MD_MUL, MD_DIVIDE, MD_FIX
    } md_state_e;

    function automatic md_op_e md_decode(input logic [5:0] opcode, input logic [5:0] funct);
        md_op_e op;
        op = MD_NONE;
        if (opcode == OP_RTYPE) begin
            case (funct)
                INS_R_MULT:  op = MD_MULT;
                INS_R_MULTU: op = MD_MULTU;
                INS_R_DIV:   op = MD_DIV;
                INS_R_DIVU:  op = MD_DIVU;
                INS_R_MFHI:  op = MD_MFHI;
                INS_R_MFLO:  op = MD_MFLO;
                INS_R_MTHI:  op = MD_MTHI;
                INS_R_MTLO:  op = MD_MTLO;
                default:     op = MD_NONE;
            endcase
        end
        return op;
    endfunction

    function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
        logic signed [31:0] a_s;
        logic signed [31:0] b_s;
        logic [31:0] r;
        a_s = a;
        b_s = b;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = {31'd0, a_s < b_s};
            ALU_SLTU: r = {31'd0, a < b};
            ALU_SLL:  r = b << sh;
            ALU_SRL:  r = b >> sh;
            ALU_SRA:  r = b_s >>> sh;
            ALU_LUI:  r = {b[15:0], 16'd0};
            default:  r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_ex_md_mdu.sv
// cpu_ex_md_mdu
//   Multi-cycle multiply/divide unit owning the HI/LO registers.
//   Ports:
//     clk, clr      clock, asynchronous active-high reset (FSM idle, HI=LO=0)
//     issue         an MD operation is accepted this cycle (only sampled when idle)
//     op            operation class (md_op_e encoding)
//     op_a, op_b    rs / rt operands
//     busy          a multiply or divide is in flight
//     hi, lo        HI/LO registers
module cpu_ex_md_mdu
    import cpu_ex_md_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_STEP   = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        issue,
    input  logic [3:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int DIV_ITERS = 32 / DIV_STEP;
    localparam int CNT_W     = 8;

    md_op_e    op_e;
    md_state_e state, state_next;
    logic [CNT_W-1:0] cnt;
    logic cnt_done, start_mul, start_div, is_signed;

    // Operands extended to 64 bits (sign or zero) so the low half of one
    // product serves both MULT and MULTU.
    logic signed [63:0] mul_a_p0, mul_b_p0;
    logic signed [63:0] prod;
    logic [31:0] rem_p0, quo_p0, den_p0, dvd_p0;
    logic neg_q_p0, neg_r_p0, den_zero_p0;
    logic [31:0] rem_step, quo_step;
    logic [32:0] trial;

    assign op_e      = md_op_e'(op);
    assign is_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
    assign start_mul = issue && (state == MD_IDLE) && (op_e == MD_MULT || op_e == MD_MULTU);
    assign start_div = issue && (state == MD_IDLE) && (op_e == MD_DIV || op_e == MD_DIVU);
    assign cnt_done  = (cnt == '0);
    assign prod      = mul_a_p0 * mul_b_p0;

    // Apply result signs; divide-by-zero returns all-ones quotient and the
    // raw dividend as remainder. INT_MIN / -1 falls out naturally as 0x80000000.
    function automatic logic [63:0] div_fixup(input logic [31:0] q, input logic [31:0] r,
                                              input logic [31:0] dvd, input logic neg_q,
                                              input logic neg_r, input logic den_zero);
        logic [31:0] q_f, r_f;
        if (den_zero) begin
            q_f = 32'hFFFF_FFFF;
            r_f = dvd;
        end else begin
            q_f = neg_q ? -q : q;
            r_f = neg_r ? -r : r;
        end
        return {r_f, q_f};
    endfunction

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start_mul)      state_next = MD_MUL;
                else if (start_div) state_next = MD_DIVIDE;
            end
            MD_MUL: begin
                busy = 1'b1;
                if (cnt_done) state_next = MD_IDLE;
            end
            MD_DIVIDE: begin
                busy = 1'b1;
                if (cnt_done) state_next = MD_FIX;
            end
            MD_FIX: begin
                busy       = 1'b1;
                state_next = MD_IDLE;
            end
            default: state_next = MD_IDLE;
        endcase
    end

    // Restoring divide, DIV_STEP quotient bits per cycle on magnitudes.
    // trial >= den guarantees trial - den fits in 32 bits.
    always_comb begin
        rem_step = rem_p0;
        quo_step = quo_p0;
        trial    = '0;
        for (int i = 0; i < DIV_STEP; i++) begin
            trial    = {rem_step, quo_step[31]};
            quo_step = {quo_step[30:0], 1'b0};
            if (trial >= {1'b0, den_p0}) begin
                rem_step    = trial[31:0] - den_p0;
                quo_step[0] = 1'b1;
            end else begin
                rem_step = trial[31:0];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= MD_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            if (start_mul)
                cnt <= CNT_W'(MUL_CYCLES - 1);
            else if (start_div)
                cnt <= CNT_W'(DIV_ITERS - 1);
            else if ((state == MD_MUL || state == MD_DIVIDE) && !cnt_done)
                cnt <= cnt - 1'b1;

            if (issue && state == MD_IDLE && op_e == MD_MTHI)
                hi <= op_a;
            if (issue && state == MD_IDLE && op_e == MD_MTLO)
                lo <= op_a;
            if (state == MD_MUL && cnt_done)
                {hi, lo} <= prod;
            if (state == MD_FIX)
                {hi, lo} <= div_fixup(quo_p0, rem_p0, dvd_p0, neg_q_p0, neg_r_p0, den_zero_p0);
        end
    end

    // Operand/partial-result registers carry no reset; the FSM gates their use.
    always_ff @(posedge clk) begin
        if (start_mul) begin
            mul_a_p0 <= {{32{is_signed & op_a[31]}}, op_a};
            mul_b_p0 <= {{32{is_signed & op_b[31]}}, op_b};
        end
        if (start_div) begin
            quo_p0      <= (is_signed && op_a[31]) ? -op_a : op_a;
            den_p0      <= (is_signed && op_b[31]) ? -op_b : op_b;
            rem_p0      <= '0;
            dvd_p0      <= op_a;
            neg_q_p0    <= is_signed & (op_a[31] ^ op_b[31]);
            neg_r_p0    <= is_signed & op_a[31];
            den_zero_p0 <= (op_b == '0);
        end else if (state == MD_DIVIDE) begin
            rem_p0 <= rem_step;
            quo_p0 <= quo_step;
        end
    end

endmodule

// File: rtl/cpu_ex_md.sv
// cpu_ex_md
//   Execute stage with HI/LO multiply/divide. Computes the ALU result,
//   branch/jump next PC and write-back destination, and latches them into
//   the EX/MEM register. MD instructions that find the unit busy stall ID/EX.
//   Ports:
//     clk, clr                 clock, asynchronous active-high reset
//     flush, hold              EX/MEM bubble request / EX/MEM keep
//     current_pc, ins, controls, reg_read1_data, reg_read2_data   ID/EX inputs
//     _syscall_reg_v0/_a0      $v0/$a0 for SYSCALL
//     ex_stall                 ID/EX must hold (comb)
//     next_pc_realtime, pc_inc_realtime, reg_write_num_realtime   comb outputs
//     current_pc_ex .. reg_write_num                              EX/MEM latch
//     md_busy, halted, _syscall_display                           status
module cpu_ex_md
    import cpu_ex_md_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_STEP   = 1,
    parameter int HALT_CODE  = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             hold,
    input  logic [31:0]      current_pc,
    input  logic [31:0]      ins,
    input  logic [CON_W-1:0] controls,
    input  logic [31:0]      reg_read1_data,
    input  logic [31:0]      reg_read2_data,
    input  logic [31:0]      _syscall_reg_v0,
    input  logic [31:0]      _syscall_reg_a0,
    output logic             ex_stall,
    output logic [31:0]      next_pc_realtime,
    output logic [1:0]       pc_inc_realtime,
    output logic [4:0]       reg_write_num_realtime,
    output logic [31:0]      current_pc_ex,
    output logic [31:0]      ins_ex,
    output logic [CON_W-1:0] controls_ex,
    output logic [31:0]      reg_read2_data_ex,
    output logic [31:0]      alu_result,
    output logic             alu_zero,
    output logic             reg_write_en,
    output logic [4:0]       reg_write_num,
    output logic             md_busy,
    output logic             halted,
    output logic [31:0]      _syscall_display
);

    md_op_e md_op;
    logic md_start, md_access, md_issue, load;
    logic [31:0] md_hi, md_lo;
    logic [31:0] imm_ext, imm_sext, alu_b, alu_out, pc_plus4, br_target, j_target;
    logic [31:0] result_next;
    logic br_taken, we_next;
    logic [4:0] num_next;

    assign md_op     = md_decode(ins[31:26], ins[5:0]);
    assign md_start  = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                       (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign md_access = (md_op == MD_MFHI) || (md_op == MD_MFLO) ||
                       (md_op == MD_MTHI) || (md_op == MD_MTLO);
    assign ex_stall  = (md_start | md_access) & md_busy & ~halted;
    assign load      = ~hold & ~flush & ~ex_stall;
    assign md_issue  = load & ~md_busy & (md_start | md_op == MD_MTHI | md_op == MD_MTLO);

    cpu_ex_md_mdu #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_STEP   (DIV_STEP)
    ) u_mdu (
        .clk   (clk),
        .clr   (clr),
        .issue (md_issue),
        .op    (md_op),
        .op_a  (reg_read1_data),
        .op_b  (reg_read2_data),
        .busy  (md_busy),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // ALU, immediate and write-back selection
    assign imm_sext = {{16{ins[15]}}, ins[15:0]};
    assign imm_ext  = controls[CON_SIGN_EXT] ? imm_sext : {16'd0, ins[15:0]};
    assign alu_b    = controls[CON_ALU_SRC_IMM] ? imm_ext : reg_read2_data;
    assign alu_out  = alu_calc(controls[CON_ALU_OP_LSB +: 4], reg_read1_data, alu_b, ins[10:6]);
    assign pc_plus4 = current_pc + 32'd4;

    always_comb begin
        result_next = alu_out;
        if (md_op == MD_MFHI)          result_next = md_hi;
        else if (md_op == MD_MFLO)     result_next = md_lo;
        else if (controls[CON_LINK])   result_next = pc_plus4;
    end

    always_comb begin
        we_next  = controls[CON_REG_WRITE] | (md_op == MD_MFHI) | (md_op == MD_MFLO);
        num_next = 5'd0;
        if (md_op == MD_MFHI || md_op == MD_MFLO) num_next = ins[15:11];
        else if (controls[CON_LINK])              num_next = 5'd31;
        else if (controls[CON_REG_DST_RD])        num_next = ins[15:11];
        else                                      num_next = ins[20:16];
        if (!we_next) num_next = 5'd0;
    end
    assign reg_write_num_realtime = num_next;

    // Branch / jump resolution
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ins[25:0], 2'b00};
    assign br_taken  = (controls[CON_BEQ] && reg_read1_data == reg_read2_data) ||
                       (controls[CON_BNE] && reg_read1_data != reg_read2_data) ||
                       controls[CON_JUMP] || controls[CON_JR];

    always_comb begin
        next_pc_realtime = pc_plus4;
        pc_inc_realtime  = br_taken ? PC_INC_TAKE : PC_INC_NORMAL;
        if (controls[CON_JR])        next_pc_realtime = reg_read1_data;
        else if (controls[CON_JUMP]) next_pc_realtime = j_target;
        else if (br_taken)           next_pc_realtime = br_target;
        if (halted) pc_inc_realtime = pc_inc_realtime | PC_INC_STOP_OR_MASK;
        if (clr) begin
            next_pc_realtime = '0;
            pc_inc_realtime  = '0;
        end
    end

    // EX/MEM register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            current_pc_ex     <= '0;
            ins_ex            <= '0;
            controls_ex       <= CON_NOP;
            reg_read2_data_ex <= '0;
            alu_result        <= '0;
            alu_zero          <= 1'b0;
            reg_write_en      <= 1'b0;
            reg_write_num     <= '0;
            halted            <= 1'b0;
            _syscall_display  <= '0;
        end else if (hold) begin
            // MEM not ready: keep everything
        end else if (flush || ex_stall) begin
            current_pc_ex     <= '0;
            ins_ex            <= '0;
            controls_ex       <= CON_NOP;
            reg_read2_data_ex <= '0;
            alu_result        <= '0;
            alu_zero          <= 1'b0;
            reg_write_en      <= 1'b0;
            reg_write_num     <= '0;
        end else begin
            current_pc_ex     <= current_pc;
            ins_ex            <= ins;
            controls_ex       <= controls;
            reg_read2_data_ex <= reg_read2_data;
            alu_result        <= result_next;
            alu_zero          <= (alu_out == '0);
            reg_write_en      <= we_next;
            reg_write_num     <= num_next;
            if (controls[CON_SYSCALL]) begin
                if (_syscall_reg_v0 == 32'(HALT_CODE)) halted <= 1'b1;
                else                                   _syscall_display <= _syscall_reg_a0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_ex_md.sv
// tb_cpu_ex_md
//   Directed vectors for the execute stage with mul/div: reset state, ALU and
//   branch results, MULT/MULTU/DIV/DIVU results and latency, stall and
//   no-stall overlap, hold/flush, syscall print/halt and clr mid-divide.
module tb_cpu_ex_md;
    import cpu_ex_md_pkg::*;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_STEP   = 1;
    localparam int HALT_CODE  = 10;

    logic             clk = 1'b0;
    logic             clr, flush, hold;
    logic [31:0]      current_pc, ins, reg_read1_data, reg_read2_data, v0, a0;
    logic [CON_W-1:0] controls;
    logic             ex_stall, alu_zero, reg_write_en, md_busy, halted;
    logic [31:0]      next_pc_realtime, current_pc_ex, ins_ex, reg_read2_data_ex, alu_result, disp;
    logic [1:0]       pc_inc_realtime;
    logic [4:0]       reg_write_num_realtime, reg_write_num;
    logic [CON_W-1:0] controls_ex;

    int n_vec = 0;
    int n_err = 0;
    int n;

    localparam logic [CON_W-1:0] C_WR_RD = (CON_W'(1) << CON_REG_WRITE) | (CON_W'(1) << CON_REG_DST_RD);
    localparam logic [CON_W-1:0] C_ADD   = C_WR_RD | CON_W'(ALU_ADD);
    localparam logic [CON_W-1:0] C_OR    = C_WR_RD | CON_W'(ALU_OR);
    localparam logic [CON_W-1:0] C_SLT   = C_WR_RD | CON_W'(ALU_SLT);
    localparam logic [CON_W-1:0] C_ADDI  = (CON_W'(1) << CON_REG_WRITE) | (CON_W'(1) << CON_ALU_SRC_IMM) |
                                           (CON_W'(1) << CON_SIGN_EXT) | CON_W'(ALU_ADD);
    localparam logic [CON_W-1:0] C_BEQ   = (CON_W'(1) << CON_BEQ) | CON_W'(ALU_SUB);
    localparam logic [CON_W-1:0] C_BNE   = (CON_W'(1) << CON_BNE) | CON_W'(ALU_SUB);
    localparam logic [CON_W-1:0] C_J     = CON_W'(1) << CON_JUMP;
    localparam logic [CON_W-1:0] C_JAL   = (CON_W'(1) << CON_JUMP) | (CON_W'(1) << CON_LINK) |
                                           (CON_W'(1) << CON_REG_WRITE);
    localparam logic [CON_W-1:0] C_SYS   = CON_W'(1) << CON_SYSCALL;

    cpu_ex_md #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_STEP   (DIV_STEP),
        .HALT_CODE  (HALT_CODE)
    ) dut (
        .clk                    (clk),
        .clr                    (clr),
        .flush                  (flush),
        .hold                   (hold),
        .current_pc             (current_pc),
        .ins                    (ins),
        .controls               (controls),
        .reg_read1_data         (reg_read1_data),
        .reg_read2_data         (reg_read2_data),
        ._syscall_reg_v0        (v0),
        ._syscall_reg_a0        (a0),
        .ex_stall               (ex_stall),
        .next_pc_realtime       (next_pc_realtime),
        .pc_inc_realtime        (pc_inc_realtime),
        .reg_write_num_realtime (reg_write_num_realtime),
        .current_pc_ex          (current_pc_ex),
        .ins_ex                 (ins_ex),
        .controls_ex            (controls_ex),
        .reg_read2_data_ex      (reg_read2_data_ex),
        .alu_result             (alu_result),
        .alu_zero               (alu_zero),
        .reg_write_en           (reg_write_en),
        .reg_write_num          (reg_write_num),
        .md_busy                (md_busy),
        .halted                 (halted),
        ._syscall_display       (disp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'd0, rs, rt, rd, 5'd0, funct};
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] i, input logic [CON_W-1:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        current_pc = pc; ins = i; controls = c; reg_read1_data = a; reg_read2_data = b;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (!md_busy) break;
            tick();
        end
        chk(tag, md_busy, 1'b0);
    endtask

    initial begin
        clr = 1'b1; flush = 1'b0; hold = 1'b0; v0 = '0; a0 = '0;
        drive(32'h100, 32'h0, CON_NOP, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_result", alu_result, 32'h0);
        chk("rst_we", reg_write_en, 1'b0);
        chk("rst_controls_ex", controls_ex, CON_NOP);
        chk("rst_pc_ex", current_pc_ex, 32'h0);
        chk("rst_busy", md_busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_display", disp, 32'h0);
        chk("rst_next_pc", next_pc_realtime, 32'h0);
        chk("rst_pc_inc", pc_inc_realtime, 2'b00);
        clr = 1'b0;

        // plain ALU ops
        drive(32'h100, rtype(5'd1, 5'd2, 5'd3, 6'h20), C_ADD, 32'd5, 32'd7);
        chk("add_num_rt", reg_write_num_realtime, 5'd3);
        tick();
        chk("add_result", alu_result, 32'd12);
        chk("add_num", reg_write_num, 5'd3);
        chk("add_we", reg_write_en, 1'b1);
        drive(32'h104, rtype(5'd1, 5'd2, 5'd3, 6'h2A), C_SLT, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("slt_result", alu_result, 32'd1);

        // branches / jumps
        drive(32'h100, {6'd4, 5'd1, 5'd2, 16'd4}, C_BEQ, 32'd5, 32'd5);
        chk("beq_next_pc", next_pc_realtime, 32'h114);
        chk("beq_pc_inc", pc_inc_realtime, PC_INC_TAKE);
        drive(32'h100, {6'd5, 5'd1, 5'd2, 16'd4}, C_BNE, 32'd5, 32'd5);
        chk("bne_next_pc", next_pc_realtime, 32'h104);
        chk("bne_pc_inc", pc_inc_realtime, PC_INC_NORMAL);
        drive(32'h100, {6'd2, 26'h123}, C_J, 32'd0, 32'd0);
        chk("j_next_pc", next_pc_realtime, 32'h48C);
        drive(32'h100, {6'd3, 26'h123}, C_JAL, 32'd0, 32'd0);
        tick();
        chk("jal_result", alu_result, 32'h104);
        chk("jal_num", reg_write_num, 5'd31);

        // MULT -1*2, then MFLO stalls for the multiply latency
        drive(32'h200, rtype(5'd1, 5'd2, 5'd0, INS_R_MULT), CON_NOP, 32'hFFFF_FFFF, 32'd2);
        chk("mult_no_stall", ex_stall, 1'b0);
        tick();
        chk("mult_busy", md_busy, 1'b1);
        drive(32'h204, rtype(5'd0, 5'd0, 5'd4, INS_R_MFLO), CON_NOP, 32'd0, 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ex_stall) break;
            n++;
            tick();
            chk("stall_bubble_we", reg_write_en, 1'b0);
        end
        chk("mult_stall_cycles", n, MUL_CYCLES);
        tick();
        chk("mult_lo", alu_result, 32'hFFFF_FFFE);
        chk("mflo_num", reg_write_num, 5'd4);
        chk("mflo_we", reg_write_en, 1'b1);
        drive(32'h208, rtype(5'd0, 5'd0, 5'd5, INS_R_MFHI), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("mult_hi", alu_result, 32'hFFFF_FFFF);

        // MULTU same operands
        drive(32'h20C, rtype(5'd1, 5'd2, 5'd0, INS_R_MULTU), CON_NOP, 32'hFFFF_FFFF, 32'd2);
        tick();
        wait_idle("multu_done");
        drive(32'h210, rtype(5'd0, 5'd0, 5'd5, INS_R_MFHI), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("multu_hi", alu_result, 32'h0000_0001);
        drive(32'h214, rtype(5'd0, 5'd0, 5'd4, INS_R_MFLO), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("multu_lo", alu_result, 32'hFFFF_FFFE);

        // DIV -7/2 with latency
        drive(32'h300, rtype(5'd1, 5'd2, 5'd0, INS_R_DIV), CON_NOP, 32'hFFFF_FFF9, 32'd2);
        tick();
        drive(32'h304, 32'h0, CON_NOP, 32'd0, 32'd0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!md_busy) break;
            n++;
            tick();
        end
        chk("div_latency", n, 32 / DIV_STEP + 1);
        drive(32'h308, rtype(5'd0, 5'd0, 5'd4, INS_R_MFLO), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("div_lo", alu_result, 32'hFFFF_FFFD);
        drive(32'h30C, rtype(5'd0, 5'd0, 5'd5, INS_R_MFHI), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("div_hi", alu_result, 32'hFFFF_FFFF);

        // DIVU 7/0
        drive(32'h310, rtype(5'd1, 5'd2, 5'd0, INS_R_DIVU), CON_NOP, 32'd7, 32'd0);
        tick();
        wait_idle("divu0_done");
        drive(32'h314, rtype(5'd0, 5'd0, 5'd4, INS_R_MFLO), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("divu0_lo", alu_result, 32'hFFFF_FFFF);
        drive(32'h318, rtype(5'd0, 5'd0, 5'd5, INS_R_MFHI), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("divu0_hi", alu_result, 32'd7);

        // DIV INT_MIN / -1
        drive(32'h31C, rtype(5'd1, 5'd2, 5'd0, INS_R_DIV), CON_NOP, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        wait_idle("divmin_done");
        drive(32'h320, rtype(5'd0, 5'd0, 5'd4, INS_R_MFLO), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("divmin_lo", alu_result, 32'h8000_0000);
        drive(32'h324, rtype(5'd0, 5'd0, 5'd5, INS_R_MFHI), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("divmin_hi", alu_result, 32'h0);

        // MTLO then MFLO
        drive(32'h328, rtype(5'd1, 5'd0, 5'd0, INS_R_MTLO), CON_NOP, 32'h55, 32'd0);
        tick();
        drive(32'h32C, rtype(5'd0, 5'd0, 5'd4, INS_R_MFLO), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("mtlo_mflo", alu_result, 32'h55);

        // MULT overlapped with three independent ALU ops
        drive(32'h400, rtype(5'd1, 5'd2, 5'd0, INS_R_MULT), CON_NOP, 32'd3, 32'd4);
        tick();
        drive(32'h404, rtype(5'd1, 5'd2, 5'd6, 6'h20), C_ADD, 32'd1, 32'd2);
        chk("ov1_stall", ex_stall, 1'b0);
        chk("ov1_busy", md_busy, 1'b1);
        tick();
        chk("ov1_result", alu_result, 32'd3);
        drive(32'h408, rtype(5'd1, 5'd2, 5'd7, 6'h25), C_OR, 32'hF0, 32'h0F);
        chk("ov2_stall", ex_stall, 1'b0);
        chk("ov2_busy", md_busy, 1'b1);
        tick();
        chk("ov2_result", alu_result, 32'hFF);
        drive(32'h40C, {6'd8, 5'd1, 5'd8, 16'hFFFF}, C_ADDI, 32'd10, 32'd0);
        chk("ov3_stall", ex_stall, 1'b0);
        chk("ov3_busy", md_busy, 1'b1);
        tick();
        chk("ov3_result", alu_result, 32'd9);
        chk("ov3_num", reg_write_num, 5'd8);
        wait_idle("ov_mult_done");
        drive(32'h410, rtype(5'd0, 5'd0, 5'd9, INS_R_MFLO), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("ov_mflo", alu_result, 32'd12);

        // hold + flush keeps; flush alone bubbles
        hold = 1'b1; flush = 1'b1;
        drive(32'h414, rtype(5'd1, 5'd2, 5'd3, 6'h20), C_ADD, 32'd1, 32'd1);
        tick();
        chk("hold_result", alu_result, 32'd12);
        chk("hold_num", reg_write_num, 5'd9);
        chk("hold_pc", current_pc_ex, 32'h410);
        hold = 1'b0;
        tick();
        chk("flush_we", reg_write_en, 1'b0);
        chk("flush_con", controls_ex, CON_NOP);
        chk("flush_result", alu_result, 32'h0);
        flush = 1'b0;

        // SYSCALL print then halt
        v0 = 32'd1; a0 = 32'h1234;
        drive(32'h500, rtype(5'd0, 5'd0, 5'd0, INS_R_SYSCALL), C_SYS, 32'd0, 32'd0);
        tick();
        chk("sys_display", disp, 32'h1234);
        chk("sys_not_halted", halted, 1'b0);
        v0 = 32'd10; a0 = 32'h9999;
        drive(32'h504, rtype(5'd0, 5'd0, 5'd0, INS_R_SYSCALL), C_SYS, 32'd0, 32'd0);
        tick();
        chk("sys_halted", halted, 1'b1);
        chk("sys_display_kept", disp, 32'h1234);
        drive(32'h508, 32'h0, CON_NOP, 32'd0, 32'd0);
        chk("halt_pc_inc", pc_inc_realtime, PC_INC_STOP_OR_MASK);

        // clr during a divide
        drive(32'h600, rtype(5'd1, 5'd2, 5'd0, INS_R_DIV), CON_NOP, 32'd100, 32'd3);
        tick();
        drive(32'h604, 32'h0, CON_NOP, 32'd0, 32'd0);
        repeat (3) tick();
        chk("clrdiv_busy_before", md_busy, 1'b1);
        clr = 1'b1;
        #1;
        chk("clrdiv_busy", md_busy, 1'b0);
        chk("clrdiv_halted", halted, 1'b0);
        chk("clrdiv_next_pc", next_pc_realtime, 32'h0);
        tick();
        clr = 1'b0;
        drive(32'h608, rtype(5'd0, 5'd0, 5'd5, INS_R_MFHI), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("clrdiv_hi", alu_result, 32'h0);
        drive(32'h60C, rtype(5'd0, 5'd0, 5'd4, INS_R_MFLO), CON_NOP, 32'd0, 32'd0);
        tick();
        chk("clrdiv_lo", alu_result, 32'h0);
        chk("clrdiv_still_idle", md_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
